// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell walks the operands LSB first, one bit per clock.
// Optional subtract mode is compiled in with `define SERIAL_SUB_EN (adds port sub).

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    count;
  logic             carry_q;
  logic             sub_q;
  logic             carry_init;
  logic             b_bit;
  logic             sum_bit;
  logic             carry_bit;

  // Subtraction is a + ~b + 1: invert b bits and seed the carry with 1.
`ifdef SERIAL_SUB_EN
  assign carry_init = sub;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sub_q <= 1'b0;
    else if (state == IDLE && start)
      sub_q <= sub;
  end
`else
  assign carry_init = 1'b0;
  assign sub_q      = 1'b0;
`endif

  assign b_bit = b_sh[0] ^ sub_q;
  assign busy  = (state == RUN);

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_bit),
    .cin  (carry_q),
    .sum  (sum_bit),
    .cout (carry_bit)
  );

  // done is registered off the DONE state, so it appears WIDTH+1 edges after the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      count     <= '0;
      carry_q   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            count   <= '0;
            carry_q <= carry_init;
            state   <= RUN;
          end
        end
        RUN: begin
          result  <= {sum_bit, result[WIDTH-1:1]};
          carry_q <= carry_bit;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          count   <= count + 1'b1;
          // carry_q still holds the carry into the MSB on the last bit.
          if (count == LAST_BIT) begin
            carry_out <= carry_bit;
            overflow  <= carry_q ^ carry_bit;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=32.
// Define SERIAL_SUB_EN for both files to exercise subtract mode.

module tb_serial_adder_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
`ifdef SERIAL_SUB_EN
  logic        sub;
`endif
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;

  int check_count = 0;
  int pass_count  = 0;

  serial_adder_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SERIAL_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one operation and waits (bounded) for done; reports latency in edges after acceptance.
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b, input bit scramble,
                        output int lat, output int busy_cycles, output bit single_pulse);
    a = op_a;
    b = op_b;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 100) begin
      if (scramble) begin
        a = $urandom;
        b = $urandom;
      end
      tick();
      lat++;
      if (busy === 1'b1) busy_cycles++;
    end
    tick();
    single_pulse = (done === 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef SERIAL_SUB_EN
    sub = 1'b0;
`endif
    #2;
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else pass_count++;
    check_count++;
    if (done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done); else pass_count++;
    check_count++;
    if (result !== 32'h0) $display("[TB] FAIL reset_result got %h want 00000000", result); else pass_count++;
    check_count++;
    if (carry_out !== 1'b0) $display("[TB] FAIL reset_carry got %b want 0", carry_out); else pass_count++;
    check_count++;
    if (overflow !== 1'b0) $display("[TB] FAIL reset_ovf got %b want 0", overflow); else pass_count++;
    tick();
    tick();
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add(input string name, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [31:0] exp_res, input logic exp_co, input logic exp_ov);
    int lat;
    int bc;
    bit one;
    run_op(op_a, op_b, 1'b0, lat, bc, one);
    check_count++;
    if (result !== exp_res) $display("[TB] FAIL %s_result got %h want %h", name, result, exp_res); else pass_count++;
    check_count++;
    if (carry_out !== exp_co) $display("[TB] FAIL %s_carry got %b want %b", name, carry_out, exp_co); else pass_count++;
    check_count++;
    if (overflow !== exp_ov) $display("[TB] FAIL %s_ovf got %b want %b", name, overflow, exp_ov); else pass_count++;
    check_count++;
    if (lat != 33) $display("[TB] FAIL %s_latency got %0d want 33", name, lat); else pass_count++;
    check_count++;
    if (bc != 32) $display("[TB] FAIL %s_busy_cycles got %0d want 32", name, bc); else pass_count++;
    check_count++;
    if (!one) $display("[TB] FAIL %s_done_width got >1 cycle want 1", name); else pass_count++;
  endtask

  task automatic test_operand_isolation();
    int lat;
    int bc;
    bit one;
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, lat, bc, one);
    check_count++;
    if (result !== 32'h2222_2221) $display("[TB] FAIL iso_result got %h want 22222221", result); else pass_count++;
    // The held result must survive idle cycles with operands changing.
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    repeat (5) tick();
    check_count++;
    if (result !== 32'h2222_2221) $display("[TB] FAIL hold_result got %h want 22222221", result); else pass_count++;
  endtask

  task automatic test_start_ignored();
    bit done_seen;
    int busy_after;
    a = 32'd5;
    b = 32'd7;
    start = 1'b1;
    tick();
    done_seen = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      start = ((i >= 5 && i <= 8) || i == 33) ? 1'b1 : 1'b0;
      tick();
      if (done === 1'b1) done_seen = (i == 33);
    end
    start = 1'b0;
    check_count++;
    if (!done_seen) $display("[TB] FAIL ignore_done_edge got no done at edge 33 want done at 33"); else pass_count++;
    busy_after = 0;
    repeat (6) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0) busy_after++;
    end
    check_count++;
    if (busy_after != 0) $display("[TB] FAIL ignore_requeue got %0d active cycles want 0", busy_after); else pass_count++;
    check_count++;
    if (result !== 32'd12) $display("[TB] FAIL ignore_result got %h want 0000000c", result); else pass_count++;
  endtask

  task automatic test_reset_mid_run();
    int spurious;
    int lat;
    int bc;
    bit one;
    a = 32'hAAAA_0000;
    b = 32'h0000_5555;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2;
    reset = 1'b1;
    #1;
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL midrst_busy got %b want 0", busy); else pass_count++;
    check_count++;
    if (result !== 32'h0) $display("[TB] FAIL midrst_result got %h want 00000000", result); else pass_count++;
    tick();
    #3;
    reset = 1'b0;
    spurious = 0;
    repeat (40) begin
      tick();
      if (done !== 1'b0) spurious++;
    end
    check_count++;
    if (spurious != 0) $display("[TB] FAIL midrst_no_done got %0d pulses want 0", spurious); else pass_count++;
    run_op(32'd5, 32'd7, 1'b0, lat, bc, one);
    check_count++;
    if (result !== 32'd12) $display("[TB] FAIL midrst_after got %h want 0000000c", result); else pass_count++;
    check_count++;
    if (lat != 33) $display("[TB] FAIL midrst_after_latency got %0d want 33", lat); else pass_count++;
  endtask

  task automatic test_back_to_back();
    int exp_done;
    int acc;
    int n_done;
    logic [31:0] pa [0:127];
    logic [31:0] pb [0:127];
    logic [32:0] full;
    logic exp_ov;
    acc = 0;
    exp_done = 33;
    n_done = 0;
    start = 1'b1;
    for (int k = 0; k < 106; k++) begin
      pa[k] = 32'h0101_0101 * (k + 1);
      pb[k] = 32'h8F00_00F3 ^ (k * 7);
      a = pa[k];
      b = pb[k];
      tick();
      if (done === 1'b1) begin
        full = {1'b0, pa[acc]} + {1'b0, pb[acc]};
        exp_ov = (pa[acc][31] == pb[acc][31]) && (full[31] != pa[acc][31]);
        check_count++;
        if (k != exp_done) $display("[TB] FAIL b2b_done_edge got %0d want %0d", k, exp_done); else pass_count++;
        check_count++;
        if (result !== full[31:0]) $display("[TB] FAIL b2b_result got %h want %h", result, full[31:0]); else pass_count++;
        check_count++;
        if (carry_out !== full[32] || overflow !== exp_ov)
          $display("[TB] FAIL b2b_flags got co=%b ov=%b want co=%b ov=%b", carry_out, overflow, full[32], exp_ov);
        else pass_count++;
        n_done++;
        acc += 34;
        exp_done += 34;
      end
    end
    start = 1'b0;
    check_count++;
    if (n_done != 3) $display("[TB] FAIL b2b_count got %0d want 3", n_done); else pass_count++;
    repeat (40) tick();
  endtask

`ifdef SERIAL_SUB_EN
  task automatic test_subtract();
    int lat;
    int bc;
    bit one;
    sub = 1'b1;
    run_op(32'd3, 32'd5, 1'b0, lat, bc, one);
    check_count++;
    if (result !== 32'hFFFF_FFFE) $display("[TB] FAIL sub_result got %h want fffffffe", result); else pass_count++;
    check_count++;
    if (carry_out !== 1'b0 || overflow !== 1'b0)
      $display("[TB] FAIL sub_flags got co=%b ov=%b want co=0 ov=0", carry_out, overflow);
    else pass_count++;
    run_op(32'd5, 32'd3, 1'b0, lat, bc, one);
    check_count++;
    if (result !== 32'd2 || carry_out !== 1'b1)
      $display("[TB] FAIL sub_noborrow got %h co=%b want 00000002 co=1", result, carry_out);
    else pass_count++;
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_add("basic", 32'd5, 32'd7, 32'h0000_000C, 1'b0, 1'b0);
    test_add("carry", 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b0);
    test_add("ovf", 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
    test_add("negovf", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
    test_operand_isolation();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SERIAL_SUB_EN
    test_subtract();
`endif
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL provide port a  input  WIDTH  first operand.
REQ-006 SHALL provide port b  input  WIDTH  second operand.
REQ-007 SHALL provide port sub  input  1  subtract select; present only when SERIAL_SUB_EN is defined.
REQ-008 SHALL provide port busy  output  1  high while in RUN.
REQ-009 SHALL provide port done  output  1  one-cycle completion pulse.
REQ-010 SHALL provide port result  output  WIDTH  sum/difference; valid from done until the next accepted start.
REQ-011 SHALL provide port carry_out  output  1  final carry from MSB.
REQ-012 SHALL provide port overflow  output  1  two's-complement signed overflow.

Function
REQ-013 SHALL compute with exactly one instance of the team's 1-bit full_adder cell, one bit per clock, LSB first.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: start=1 at an edge SHALL latch a and b into shift registers, clear the bit counter, load the carry register with 0, and go to RUN.
REQ-016 RUN: each edge SHALL shift one sum bit into result MSB-first-in (result shifts right), store the adder carry, shift operands right, and increment the counter.
REQ-017 RUN SHALL last exactly WIDTH cycles; after the edge that processes bit WIDTH-1, the FSM SHALL enter DONE.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-019 done SHALL first be high WIDTH+1 clock edges after the edge that accepted start.
REQ-020 start asserted in RUN or DONE SHALL be ignored (not queued).
REQ-021 Operand inputs SHALL be ignored after the accepting edge; changes in RUN SHALL not affect the result.
REQ-022 carry_out SHALL equal the carry produced at bit WIDTH-1.
REQ-023 overflow SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-024 result, carry_out, overflow SHALL hold their values from DONE through IDLE until the next accepted start; they are undefined-but-stable during RUN.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; no saturation.

Reset
REQ-026 reset=1 SHALL immediately, without clk, force state IDLE and busy=0, done=0, result=0, carry_out=0, overflow=0, counter=0, carry register=0.
REQ-027 reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.
REQ-028 start coincident with the reset-release edge SHALL be ignored only if reset is still high at that edge.

Configuration
REQ-029 With macro SERIAL_SUB_EN defined, sub SHALL be latched with the operands; sub=1 SHALL feed inverted b bits to the adder and load carry register with 1, yielding a-b; carry_out=1 means no borrow.
REQ-030 Without SERIAL_SUB_EN, port sub SHALL not exist and the block SHALL only add.

Verification (WIDTH=32)
REQ-031 reset pulse mid-operation -> busy=0, done never pulses, result=0; subsequent 5+7 -> result=12.
REQ-032 a=5, b=7, start one cycle -> busy high 32 cycles, done at edge 33, result=0x0000000C, carry_out=0, overflow=0.
REQ-033 a=0xFFFFFFFF, b=1 -> result=0, carry_out=1, overflow=0.
REQ-034 a=0x7FFFFFFF, b=1 -> result=0x80000000, carry_out=0, overflow=1.
REQ-035 start held high continuously, operands toggled during RUN -> one done per 34 cycles, results match operands at each accepting edge.
REQ-036 SERIAL_SUB_EN defined, a=3, b=5, sub=1 -> result=0xFFFFFFFE, carry_out=0, overflow=0.
